// File: rtl/pwm_fade_pkg.sv
// Shared types and constants for the PWM fade sequencer.
// State encoding, sweep direction and PWM write-select codes.
package pwm_fade_pkg;

  typedef enum logic [2:0] {
    IDLE,
    W_TOP,
    W_CNT,
    W_CMP,
    HOLD,
    W_FIN
  } state_e;

  typedef enum logic {
    DIR_UP,
    DIR_DOWN
  } dir_e;

  localparam logic [1:0] SEL_NOP = 2'd0;
  localparam logic [1:0] SEL_CMP = 2'd1;
  localparam logic [1:0] SEL_TOP = 2'd2;
  localparam logic [1:0] SEL_CNT = 2'd3;

endpackage

// File: rtl/pwm_fade_timer.sv
// Loadable down-counter that times the hold gap between compare writes.
// Stops at zero; load wins over decrement.
module fade_timer #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pwm_fade.sv
// Drives a PWM write bus: programs the period, clears the counter, then
// ramps the compare value up and down for a set number of sweeps.
module pwm_fade
  import pwm_fade_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic [W-1:0] top_in,
  input  logic [W-1:0] step_in,
  input  logic [W-1:0] hold_in,
  input  logic [7:0]   sweeps_in,
  output logic [1:0]   sel,
  output logic [W-1:0] d,
  output logic         busy,
  output logic         done
);

  state_e       state_q, state_d;
  dir_e         dir_q, dir_d;
  logic [W-1:0] top_q, top_d;
  logic [W-1:0] step_q, step_d;
  logic [W-1:0] hold_q, hold_d;
  logic [7:0]   sweeps_q, sweeps_d;
  logic [7:0]   sweep_q, sweep_d;
  logic [W-1:0] cmp_q, cmp_d;
  logic         end_q, end_d;
  logic [1:0]   sel_q, sel_d;
  logic [W-1:0] d_q, d_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic         tmr_load;
  logic         tmr_en;
  logic         tmr_zero;
  logic [W:0]   sum;
  logic         last_wr;

  fade_timer #(
    .W(W)
  ) u_timer (
    .clk_i     (clk),
    .rst_i     (rst),
    .load_i    (tmr_load),
    .load_val_i(hold_q - 1'b1),
    .en_i      (tmr_en),
    .zero_o    (tmr_zero)
  );

  // One extra bit so cmp+step never wraps before the top compare.
  assign sum     = {1'b0, cmp_q} + {1'b0, step_q};
  assign last_wr = end_q && (sweep_q == sweeps_q);

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    top_d    = top_q;
    step_d   = step_q;
    hold_d   = hold_q;
    sweeps_d = sweeps_q;
    sweep_d  = sweep_q;
    cmp_d    = cmp_q;
    end_d    = end_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          top_d    = top_in;
          step_d   = (step_in == '0) ? {{(W-1){1'b0}}, 1'b1} : step_in;
          hold_d   = hold_in;
          sweeps_d = (sweeps_in == 8'd0) ? 8'd1 : sweeps_in;
          state_d  = W_TOP;
        end
      end
      W_TOP: begin
        state_d = W_CNT;
      end
      W_CNT: begin
        cmp_d   = '0;
        dir_d   = DIR_UP;
        sweep_d = 8'd0;
        end_d   = 1'b0;
        state_d = W_CMP;
      end
      W_CMP: begin
        if (last_wr) begin
          state_d = IDLE;
        end else begin
          end_d = 1'b0;
          if (dir_q == DIR_UP) begin
            if (sum >= {1'b0, top_q}) begin
              // A zero period ends the sweep on the turn-around itself.
              if (top_q == '0) begin
                cmp_d   = '0;
                sweep_d = sweep_q + 8'd1;
                end_d   = 1'b1;
              end else begin
                cmp_d = top_q;
                dir_d = DIR_DOWN;
              end
            end else begin
              cmp_d = sum[W-1:0];
            end
          end else begin
            if (cmp_q <= step_q) begin
              cmp_d   = '0;
              dir_d   = DIR_UP;
              sweep_d = sweep_q + 8'd1;
              end_d   = 1'b1;
            end else begin
              cmp_d = cmp_q - step_q;
            end
          end
          if (hold_q != '0) begin
            tmr_load = 1'b1;
            state_d  = HOLD;
          end else begin
            state_d = W_CMP;
          end
        end
      end
      HOLD: begin
        tmr_en = 1'b1;
        if (tmr_zero) begin
          state_d = W_CMP;
        end
      end
      W_FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (stop && (state_q != IDLE)) begin
      state_d = W_FIN;
    end

    sel_d  = SEL_NOP;
    d_d    = '0;
    busy_d = (state_d != IDLE);
    done_d = (state_q == W_CMP) && (state_d == IDLE);

    unique case (state_d)
      W_TOP: begin
        sel_d = SEL_TOP;
        d_d   = top_d;
      end
      W_CNT: begin
        sel_d = SEL_CNT;
      end
      W_CMP: begin
        sel_d = SEL_CMP;
        d_d   = cmp_d;
      end
      W_FIN: begin
        sel_d = SEL_CMP;
      end
      default: begin
        sel_d = SEL_NOP;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      dir_q    <= DIR_UP;
      top_q    <= '0;
      step_q   <= '0;
      hold_q   <= '0;
      sweeps_q <= 8'd0;
      sweep_q  <= 8'd0;
      cmp_q    <= '0;
      end_q    <= 1'b0;
      sel_q    <= SEL_NOP;
      d_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      top_q    <= top_d;
      step_q   <= step_d;
      hold_q   <= hold_d;
      sweeps_q <= sweeps_d;
      sweep_q  <= sweep_d;
      cmp_q    <= cmp_d;
      end_q    <= end_d;
      sel_q    <= sel_d;
      d_q      <= d_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign sel  = sel_q;
  assign d    = d_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_pwm_fade.sv
// Bench for pwm_fade: expected write streams are built from the sweep
// rules and compared cycle by cycle against the DUT bus.
module tb_pwm_fade;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] top_in = '0;
  logic [15:0] step_in = '0;
  logic [15:0] hold_in = '0;
  logic [7:0]  sweeps_in = '0;
  logic [1:0]  sel;
  logic [15:0] d;
  logic        busy;
  logic        done;

  int vectors = 0;
  int miscompares = 0;

  pwm_fade #(
    .W(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .top_in   (top_in),
    .step_in  (step_in),
    .hold_in  (hold_in),
    .sweeps_in(sweeps_in),
    .sel      (sel),
    .d        (d),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Register file of the downstream PWM generator.
  logic [15:0] pwm_top = '0;
  logic [15:0] pwm_cmp = '0;
  logic [15:0] pwm_cnt = '0;

  always @(posedge clk) begin
    case (sel)
      2'd1:    pwm_cmp <= d;
      2'd2:    pwm_top <= d;
      2'd3:    pwm_cnt <= d;
      default: pwm_cnt <= (pwm_cnt >= pwm_top) ? 16'd0 : pwm_cnt + 16'd1;
    endcase
  end

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] d;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build(input int top, input int step, input int hold,
                       input int sweeps);
    int vals[$];
    int c;
    int st;
    int sw;
    st = (step == 0) ? 1 : step;
    sw = (sweeps == 0) ? 1 : sweeps;
    q.delete();
    vals.push_back(0);
    for (int s = 0; s < sw; s++) begin
      if (top == 0) begin
        vals.push_back(0);
      end else begin
        c = 0;
        do begin
          c = (c + st >= top) ? top : c + st;
          vals.push_back(c);
        end while (c != top);
        do begin
          c = (c <= st) ? 0 : c - st;
          vals.push_back(c);
        end while (c != 0);
      end
    end
    q.push_back('{2'd2, 16'(top), 1'b1, 1'b0});
    q.push_back('{2'd3, 16'd0, 1'b1, 1'b0});
    for (int i = 0; i < vals.size(); i++) begin
      q.push_back('{2'd1, 16'(vals[i]), 1'b1, 1'b0});
      if (i != vals.size() - 1) begin
        for (int h = 0; h < hold; h++) begin
          q.push_back('{2'd0, 16'd0, 1'b1, 1'b0});
        end
      end
    end
    q.push_back('{2'd0, 16'd0, 1'b0, 1'b1});
    q.push_back('{2'd0, 16'd0, 1'b0, 1'b0});
  endtask

  task automatic run(input int top, input int step, input int hold,
                     input int sweeps, input int stop_at, input int poke);
    int ncmp;
    build(top, step, hold, sweeps);
    top_in    = 16'(top);
    step_in   = 16'(step);
    hold_in   = 16'(hold);
    sweeps_in = 8'(sweeps);
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ncmp  = 0;
    for (int i = 0; i < q.size(); i++) begin
      if (i > 0) @(negedge clk);
      start = (i == poke);
      chk("sel", 32'(sel), 32'(q[i].sel));
      if (q[i].sel != 2'd0) chk("d", 32'(d), 32'(q[i].d));
      chk("busy", 32'(busy), 32'(q[i].busy));
      chk("done", 32'(done), 32'(q[i].done));
      if (q[i].sel == 2'd1) ncmp++;
      if ((q[i].sel == 2'd1) && (ncmp == stop_at)) begin
        stop = 1'b1;
        @(negedge clk);
        stop  = 1'b0;
        start = 1'b0;
        chk("fin_sel", 32'(sel), 32'd1);
        chk("fin_d", 32'(d), 32'd0);
        chk("fin_busy", 32'(busy), 32'd1);
        chk("fin_done", 32'(done), 32'd0);
        @(negedge clk);
        chk("abort_sel", 32'(sel), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_pwm_cmp", 32'(pwm_cmp), 32'd0);
        @(negedge clk);
        chk("abort_done2", 32'(done), 32'd0);
        return;
      end
    end
    start = 1'b0;
    chk("pwm_cmp", 32'(pwm_cmp), 32'd0);
    chk("pwm_top", 32'(pwm_top), 32'(top));
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_d", 32'(d), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run(100, 50, 2, 1, -1, -1);
    run(100, 60, 0, 2, -1, -1);
    run(3, 0, 0, 1, -1, -1);
    run(1000, 10, 1, 1, 5, -1);
    run(100, 50, 1, 1, -1, 4);
    run(0, 0, 0, 1, -1, -1);
    run(5, 2, 1, 0, -1, -1);

    top_in    = 16'd100;
    step_in   = 16'd50;
    hold_in   = 16'd5;
    sweeps_in = 8'd1;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_sel", 32'(sel), 32'd0);
    chk("mid_rst_d", 32'(d), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run(100, 50, 2, 1, -1, -1);

    for (int r = 0; r < 8; r++) begin
      run(int'($urandom_range(0, 40)), int'($urandom_range(0, 15)),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
